// File: rtl/program_rom.sv
// ---------------------------------------------------------------------------
// program_rom
//
// Read-only program/data store for the 8-bit teaching CPU. It holds 16 words
// of 8 bits, addressed by the program counter or the memory-address register.
// The addressed word is returned combinationally for instruction fetch and
// operand load. A one-cycle registered copy is also provided for pipelined
// consumers downstream.
//
// Word format: [7:4] opcode, [3:0] operand address.
// Opcodes: LDA=0x0, ADD=0x1, SUB=0x2, OUT=0xE, HLT=0xF.
//
// Ports:
//   clk        in   1  system clock, rising-edge active
//   rst        in   1  synchronous active-high reset (registered copy only)
//   rom_addr   in   4  word address 0x0-0xF
//   rom_out    out  8  combinational read data for rom_addr
//   rom_out_q  out  8  rom_out registered on clk, cleared by rst
// ---------------------------------------------------------------------------
module program_rom (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rom_addr,
  output logic [7:0] rom_out,
  output logic [7:0] rom_out_q
);

  // Opcode fields, used to keep the program listing below readable.
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [7:0] w_romData;
  logic [7:0] r_romOutQ;

  // Address decode for the fixed contents. The default branch matters in
  // simulation: an address containing X or Z bits matches none of the
  // explicit items and falls through to 0x00, so the read data never goes X.
  always_comb begin
    w_romData = 8'h00;
    case (rom_addr)
      4'h0:    w_romData = {OP_LDA, 4'h9};
      4'h1:    w_romData = {OP_ADD, 4'hA};
      4'h2:    w_romData = {OP_ADD, 4'hB};
      4'h3:    w_romData = {OP_SUB, 4'hC};
      4'h4:    w_romData = {OP_OUT, 4'h0};
      4'h5:    w_romData = {OP_HLT, 4'h0};
      4'h6:    w_romData = 8'h00;
      4'h7:    w_romData = 8'h00;
      4'h8:    w_romData = 8'h00;
      4'h9:    w_romData = 8'h10;
      4'hA:    w_romData = 8'h14;
      4'hB:    w_romData = 8'h18;
      4'hC:    w_romData = 8'h04;
      4'hD:    w_romData = 8'h00;
      4'hE:    w_romData = 8'h00;
      4'hF:    w_romData = 8'h00;
      default: w_romData = 8'h00;
    endcase
  end

  // Registered copy for pipelined consumers. Reset only clears this copy;
  // the combinational read path keeps tracking the address during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_romOutQ <= 8'h00;
    end else begin
      r_romOutQ <= w_romData;
    end
  end

  assign rom_out   = w_romData;
  assign rom_out_q = r_romOutQ;

endmodule

// File: tb/tb_program_rom.sv
// ---------------------------------------------------------------------------
// tb_program_rom
//
// Self-checking bench for program_rom. A table of {address, expected word}
// records drives the combinational sweep. Registered-output expectations are
// pushed to a queue when stimulus is driven and popped when the flop has
// captured, one edge later.
// ---------------------------------------------------------------------------
module tb_program_rom;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] expOut;
  } romVec_t;

  logic       clk;
  logic       rst;
  logic [3:0] rom_addr;
  logic [7:0] rom_out;
  logic [7:0] rom_out_q;

  romVec_t    vecs[16];
  logic [7:0] expQ[$];
  logic [7:0] lastQ;
  logic       haveQ;
  int         assertCount;
  int         failCount;

  program_rom dut (
    .clk       (clk),
    .rst       (rst),
    .rom_addr  (rom_addr),
    .rom_out   (rom_out),
    .rom_out_q (rom_out_q)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected contents, written out independently of the design.
  function automatic logic [7:0] romModel(input logic [3:0] addr);
    romModel = vecs[addr].expOut;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of stimulus 1 ns after an edge, check that the registered
  // output still holds its previous value, then check it after the next edge.
  task automatic applyStimulus(input logic [3:0] addr, input logic rstVal);
    logic [7:0] expected;
    rom_addr = addr;
    rst      = rstVal;
    expQ.push_back(rstVal ? 8'h00 : romModel(addr));
    #1;
    checkOutput("romOutComb", rom_out, romModel(addr));
    if (haveQ) checkOutput("romOutQHold", rom_out_q, lastQ);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL scoreboardEmpty: got 0 entries, expected 1");
    end else begin
      expected = expQ.pop_front();
      checkOutput("romOutQ", rom_out_q, expected);
      lastQ = expected;
      haveQ = 1'b1;
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    haveQ       = 1'b0;
    lastQ       = 8'h00;

    vecs[0]  = '{4'h0, 8'h09};
    vecs[1]  = '{4'h1, 8'h1A};
    vecs[2]  = '{4'h2, 8'h1B};
    vecs[3]  = '{4'h3, 8'h2C};
    vecs[4]  = '{4'h4, 8'hE0};
    vecs[5]  = '{4'h5, 8'hF0};
    vecs[6]  = '{4'h6, 8'h00};
    vecs[7]  = '{4'h7, 8'h00};
    vecs[8]  = '{4'h8, 8'h00};
    vecs[9]  = '{4'h9, 8'h10};
    vecs[10] = '{4'hA, 8'h14};
    vecs[11] = '{4'hB, 8'h18};
    vecs[12] = '{4'hC, 8'h04};
    vecs[13] = '{4'hD, 8'h00};
    vecs[14] = '{4'hE, 8'h00};
    vecs[15] = '{4'hF, 8'h00};

    // Unknown address must decode to 0x00 (only meaningful in 4-state sims).
    rst      = 1'b1;
    rom_addr = 'x;
    #1;
    if ($isunknown(rom_addr)) checkOutput("romOutXAddr", rom_out, 8'h00);

    // Full combinational sweep, sampled 1 ns after each address change.
    for (int i = 0; i < 16; i++) begin
      rom_addr = vecs[i].addr;
      #1;
      checkOutput("romOutSweep", rom_out, vecs[i].expOut);
    end

    // Re-align to 1 ns after an edge before the clocked sequences.
    @(posedge clk);
    #1;

    // Reset for two cycles at address 0x4, then release.
    applyStimulus(4'h4, 1'b1);
    applyStimulus(4'h4, 1'b1);
    checkOutput("romOutDuringRst", rom_out, 8'hE0);
    applyStimulus(4'h4, 1'b0);

    // One-cycle lag on consecutive addresses.
    applyStimulus(4'h5, 1'b0);
    applyStimulus(4'h9, 1'b0);
    applyStimulus(4'hC, 1'b0);

    // Mid-stream reset while the registered copy holds 0x18.
    applyStimulus(4'hB, 1'b0);
    applyStimulus(4'hB, 1'b1);
    applyStimulus(4'hA, 1'b1);
    applyStimulus(4'h2, 1'b0);
    applyStimulus(4'h3, 1'b0);

    // Random tail with occasional resets.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end

    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboardLeftover: got %0d entries, expected 0",
               expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
